rf_writeback: RTL and testbench

Writeback controller that is the write-side master of the 32×32 register file in the single-cycle core. It merges single-cycle ALU results and variable-latency load/store-unit (LSU) responses into the register file's single write port (`reg_wr`/`waddr`/`wdata`). LSU responses are buffered in a small FIFO. A 32-bit busy scoreboard tracks outstanding LSU destinations and drives the issue stall.

---
 rtl/rf_writeback_pkg.sv | 27 ++
 rtl/rf_writeback_if.sv | 60 ++++++
 rtl/rf_writeback_wb_fifo.sv | 77 +++++++
 rtl/rf_writeback.sv | 123 ++++++++++++
 tb/tb_rf_writeback.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths and types for the register-file writeback
//               controller (register address, LSU response FIFO entry).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef logic [4:0] regaddr_t;

    // One buffered LSU response: destination register and its data.
    typedef struct packed {
        regaddr_t          rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired to zero, so only non-zero destinations are real writes.
    function automatic logic writes_reg(input regaddr_t rd);
        return (rd != '0);
    endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_if
// Description : Bundles the ALU result, LSU request/response, issue-check and
//               register-file write-port signals of the writeback controller.
//               'master' is the core side feeding the controller, 'slave' is
//               the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_if;
    import rf_pkg::*;

    // ALU result path (never back-pressured)
    logic               alu_valid;
    regaddr_t           alu_rd;
    logic [XLEN-1:0]    alu_result;

    // LSU issue: marks a destination busy
    logic               lsu_req_valid;
    regaddr_t           lsu_req_rd;

    // LSU response handshake
    logic               lsu_resp_valid;
    logic               lsu_resp_ready;
    regaddr_t           lsu_resp_rd;
    logic [XLEN-1:0]    lsu_resp_data;

    // Issue-stage hazard check
    regaddr_t           iss_rs1;
    regaddr_t           iss_rs2;
    regaddr_t           iss_rd;
    logic               stall;

    // Register-file write port
    logic               reg_wr;
    regaddr_t           waddr;
    logic [XLEN-1:0]    wdata;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output lsu_req_valid, lsu_req_rd,
        output lsu_resp_valid, lsu_resp_rd, lsu_resp_data,
        input  lsu_resp_ready,
        output iss_rs1, iss_rs2, iss_rd,
        input  stall,
        input  reg_wr, waddr, wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  lsu_req_valid, lsu_req_rd,
        input  lsu_resp_valid, lsu_resp_rd, lsu_resp_data,
        output lsu_resp_ready,
        input  iss_rs1, iss_rs2, iss_rd,
        output stall,
        output reg_wr, waddr, wdata
    );

endinterface : rf_writeback_if
`default_nettype wire

// File: rtl/rf_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO buffering LSU responses. DEPTH must be
//               a power of two (>= 2) so the pointers wrap naturally. Read
//               data is the combinational head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire T                       push_data,
    input  wire logic                   pop,
    output T                            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE   = 1;
    localparam logic [AW:0]   c_CNT_ONE   = 1;
    localparam logic [AW:0]   c_CNT_DEPTH = (AW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_push;
    logic           w_pop;

    // Overflow/underflow protection lives here so callers can be simple.
    assign w_push   = push & ~full;
    assign w_pop    = pop  & ~empty;

    assign full     = (r_count == c_CNT_DEPTH);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards all entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are meaningless until written so it has no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback
// Description : Write-side master of the 32x32 register file. Merges
//               single-cycle ALU results with buffered LSU responses onto the
//               single write port (ALU has priority), and keeps a busy
//               scoreboard of outstanding LSU destinations to stall issue.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    rf_writeback_if.slave   wb
);

    // ------------------------------------------------------------------
    // LSU response FIFO
    // ------------------------------------------------------------------
    wb_entry_t                  w_push_entry;
    wb_entry_t                  w_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [$clog2(DEPTH):0]     w_fifo_count_unused;
    logic                       w_push;
    logic                       w_pop;

    assign w_push_entry.rd   = wb.lsu_resp_rd;
    assign w_push_entry.data = wb.lsu_resp_data;

    // Ready depends only on occupancy, never on lsu_resp_valid.
    assign wb.lsu_resp_ready = ~w_fifo_full;
    assign w_push            = wb.lsu_resp_valid & ~w_fifo_full;

    // The ALU cannot be held off, so the FIFO only drains on ALU-idle cycles.
    assign w_pop             = ~wb.alu_valid & ~w_fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count_unused)
    );

    // ------------------------------------------------------------------
    // Busy scoreboard (bit 0 is permanently clear: x0 is never pending)
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0]    r_busy;
    logic [NUM_REGS-1:0]    w_busy_set;
    logic [NUM_REGS-1:0]    w_busy_clr;
    logic [NUM_REGS-1:0]    w_busy_next;

    // Set on LSU issue, clear when that register's response is written;
    // applying the set after the clear makes a same-cycle re-issue win.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (wb.lsu_req_valid && writes_reg(wb.lsu_req_rd)) begin
            w_busy_set[wb.lsu_req_rd] = 1'b1;
        end
        if (w_pop && writes_reg(w_head.rd)) begin
            w_busy_clr[w_head.rd] = 1'b1;
        end
        w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard state; reset forgets every outstanding load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Sources cover RAW, the destination term covers WAW. r_busy[0] is
    // always zero, so x0 operands never stall.
    assign wb.stall = r_busy[wb.iss_rs1] | r_busy[wb.iss_rs2] | r_busy[wb.iss_rd];

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    logic               r_reg_wr;
    regaddr_t           r_waddr;
    logic [XLEN-1:0]    r_wdata;

    // ALU first, then FIFO head; address/data hold when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_wr <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else if (wb.alu_valid) begin
            r_reg_wr <= writes_reg(wb.alu_rd);
            r_waddr  <= wb.alu_rd;
            r_wdata  <= wb.alu_result;
        end else if (w_pop) begin
            r_reg_wr <= writes_reg(w_head.rd);
            r_waddr  <= w_head.rd;
            r_wdata  <= w_head.data;
        end else begin
            r_reg_wr <= 1'b0;
        end
    end

    assign wb.reg_wr = r_reg_wr;
    assign wb.waddr  = r_waddr;
    assign wb.wdata  = r_wdata;

endmodule : rf_writeback
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_writeback
// Description : Directed self-checking bench for rf_writeback. A queue-based
//               model of the writeback rules is compared against the DUT on
//               every falling edge; directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    rf_writeback_if wb ();

    rf_writeback #(.DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of pending responses, a busy set and the
    // last value written to the register-file port.
    // ------------------------------------------------------------------
    wb_entry_t          m_q[$];
    logic [31:0]        m_busy;
    logic               m_wr;
    logic [4:0]         m_waddr;
    logic [31:0]        m_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_busy  = '0;
            m_wr    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            wb_entry_t e;
            bit        room;
            room = (m_q.size() < DEPTH);
            if (wb.alu_valid) begin
                assert (!(wb.alu_rd != 0 && m_busy[wb.alu_rd]))
                    else $error("ALU write to pending register x%0d", wb.alu_rd);
                m_wr    = (wb.alu_rd != 0);
                m_waddr = wb.alu_rd;
                m_wdata = wb.alu_result;
            end else if (m_q.size() != 0) begin
                e       = m_q.pop_front();
                m_wr    = (e.rd != 0);
                m_waddr = e.rd;
                m_wdata = e.data;
                m_busy[e.rd] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            if (wb.lsu_req_valid && wb.lsu_req_rd != 0) begin
                m_busy[wb.lsu_req_rd] = 1'b1;
            end
            if (wb.lsu_resp_valid && room) begin
                e.rd   = wb.lsu_resp_rd;
                e.data = wb.lsu_resp_data;
                m_q.push_back(e);
            end
            m_busy[0] = 1'b0;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("reg_wr", {31'b0, wb.reg_wr}, {31'b0, m_wr});
            check("waddr",  {27'b0, wb.waddr},  {27'b0, m_waddr});
            check("wdata",  wb.wdata, m_wdata);
            check("lsu_resp_ready", {31'b0, wb.lsu_resp_ready},
                  {31'b0, (m_q.size() < DEPTH)});
            check("stall", {31'b0, wb.stall},
                  {31'b0, (m_busy[wb.iss_rs1] | m_busy[wb.iss_rs2] | m_busy[wb.iss_rd])});
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        wb.alu_valid      = 1'b0;
        wb.alu_rd         = '0;
        wb.alu_result     = '0;
        wb.lsu_req_valid  = 1'b0;
        wb.lsu_req_rd     = '0;
        wb.lsu_resp_valid = 1'b0;
        wb.lsu_resp_rd    = '0;
        wb.lsu_resp_data  = '0;
        wb.iss_rs1        = '0;
        wb.iss_rs2        = '0;
        wb.iss_rd         = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = rd;
        wb.alu_result = d;
    endtask

    task automatic resp(input logic [4:0] rd, input logic [31:0] d);
        wb.lsu_resp_valid = 1'b1;
        wb.lsu_resp_rd    = rd;
        wb.lsu_resp_data  = d;
    endtask

    task automatic expect_wr(input string tag, input logic wr, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".reg_wr"}, {31'b0, wb.reg_wr}, {31'b0, wr});
        check({tag, ".waddr"},  {27'b0, wb.waddr},  {27'b0, a});
        check({tag, ".wdata"},  wb.wdata, d);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) step();
        expect_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset.ready", {31'b0, wb.lsu_resp_ready}, 32'd1);
        check("reset.stall", {31'b0, wb.stall}, 32'd0);
        reset = 1'b0;
        step();

        // 1. ALU write, then an ALU write to x0
        alu(5'd5, 32'hDEADBEEF);
        step();
        expect_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        alu(5'd0, 32'h0000_0001);
        step();
        expect_wr("alu_x0", 1'b0, 5'd0, 32'h0000_0001);
        idle();
        step();

        // 2. LSU write with scoreboard stall on RAW
        wb.lsu_req_valid = 1'b1;
        wb.lsu_req_rd    = 5'd7;
        step();
        wb.lsu_req_valid = 1'b0;
        wb.iss_rs1       = 5'd7;
        #1;
        check("lsu.stall_set", {31'b0, wb.stall}, 32'd1);
        repeat (2) step();
        resp(5'd7, 32'h0000_1234);
        step();
        wb.lsu_resp_valid = 1'b0;
        check("lsu.in_fifo_no_wr", {31'b0, wb.reg_wr}, 32'd0);
        check("lsu.stall_hold", {31'b0, wb.stall}, 32'd1);
        step();
        expect_wr("lsu", 1'b1, 5'd7, 32'h0000_1234);
        check("lsu.stall_clear", {31'b0, wb.stall}, 32'd0);
        idle();
        step();

        // 3. Contention: ALU holds the port for three cycles
        resp(5'd3, 32'h0000_AAAA);
        step();
        wb.lsu_resp_valid = 1'b0;
        check("cont.no_wr", {31'b0, wb.reg_wr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            alu(5'(10 + i), 32'h100 + 32'(i));
            step();
            expect_wr("cont.alu", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
        end
        wb.alu_valid = 1'b0;
        step();
        expect_wr("cont.lsu", 1'b1, 5'd3, 32'h0000_AAAA);

        // x0 response is accepted and popped without a write
        resp(5'd0, 32'h0000_0055);
        step();
        wb.lsu_resp_valid = 1'b0;
        step();
        expect_wr("lsu_x0", 1'b0, 5'd0, 32'h0000_0055);
        step();

        // 4. FIFO full while the ALU owns the port
        alu(5'd20, 32'h0000_2020);
        for (int i = 1; i <= 4; i++) begin
            resp(5'(i), 32'hA0 + 32'(i));
            step();
        end
        resp(5'd5, 32'hA5);
        check("full.ready_low", {31'b0, wb.lsu_resp_ready}, 32'd0);
        step();
        check("full.ready_still_low", {31'b0, wb.lsu_resp_ready}, 32'd0);
        wb.alu_valid = 1'b0;
        step();
        expect_wr("drain1", 1'b1, 5'd1, 32'hA1);
        check("drain1.ready", {31'b0, wb.lsu_resp_ready}, 32'd1);
        step();
        wb.lsu_resp_valid = 1'b0;
        expect_wr("drain2", 1'b1, 5'd2, 32'hA2);
        for (int i = 3; i <= 5; i++) begin
            step();
            expect_wr("drain", 1'b1, 5'(i), 32'hA0 + 32'(i));
        end
        step();
        check("drain.idle", {31'b0, wb.reg_wr}, 32'd0);

        // 5. Same-cycle clear and set of x9: set wins
        wb.lsu_req_valid = 1'b1;
        wb.lsu_req_rd    = 5'd9;
        step();
        wb.lsu_req_valid = 1'b0;
        resp(5'd9, 32'h99);
        step();
        wb.lsu_resp_valid = 1'b0;
        wb.lsu_req_valid  = 1'b1;
        wb.iss_rs2        = 5'd9;
        step();
        wb.lsu_req_valid = 1'b0;
        expect_wr("coll", 1'b1, 5'd9, 32'h99);
        check("coll.busy_kept", {31'b0, wb.stall}, 32'd1);
        resp(5'd9, 32'h999);
        step();
        wb.lsu_resp_valid = 1'b0;
        step();
        check("coll.busy_cleared", {31'b0, wb.stall}, 32'd0);
        idle();
        step();

        // 6. Asynchronous reset with three queued responses, busy = x7, x10
        wb.lsu_req_valid = 1'b1;
        wb.lsu_req_rd    = 5'd7;
        step();
        wb.lsu_req_rd    = 5'd10;
        step();
        wb.lsu_req_valid = 1'b0;
        alu(5'd1, 32'h11);
        for (int i = 2; i <= 4; i++) begin
            resp(5'(i), 32'hB0 + 32'(i));
            step();
        end
        idle();
        wb.iss_rs1 = 5'd7;
        wb.iss_rs2 = 5'd10;
        #1;
        check("rst.pre_stall", {31'b0, wb.stall}, 32'd1);
        check("rst.pre_wr", {31'b0, wb.reg_wr}, 32'd1);
        reset = 1'b1;
        #1;
        expect_wr("rst.async", 1'b0, 5'd0, 32'h0);
        check("rst.stall", {31'b0, wb.stall}, 32'd0);
        check("rst.ready", {31'b0, wb.lsu_resp_ready}, 32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst.no_wr", {31'b0, wb.reg_wr}, 32'd0);
        end
        check("rst.stall_after", {31'b0, wb.stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rf_writeback
`default_nettype wire
